// File: rtl/tt_eval_seq_if.sv
// Handshake and function bus of the programmable truth-table gate.
// The master drives the inputs and the serial table load; the slave is the gate itself.
interface tt_eval_seq_if #(
    parameter int N_IN = 3
);
    logic [N_IN-1:0] in;
    logic            ld_start;
    logic            ld_valid;
    logic            ld_bit;
    logic            ld_ready;
    logic            ld_done;
    logic            out;
    logic            out_valid;
    logic            out_changed;

    modport master (
        output in, ld_start, ld_valid, ld_bit,
        input  ld_ready, ld_done, out, out_valid, out_changed
    );

    modport slave (
        input  in, ld_start, ld_valid, ld_bit,
        output ld_ready, ld_done, out, out_valid, out_changed
    );
endinterface

// File: rtl/tt_eval_seq.sv
// Runtime-programmable N_IN-input truth-table gate with a glitch-rejecting settle filter
// and an atomically committed serial table load.
module tt_eval_seq #(
    parameter int                     N_IN       = 3,
    parameter int                     SETTLE     = 4,
    parameter logic [(1<<N_IN)-1:0]   DEFAULT_TT = 8'h3B
) (
    input  logic            clk,
    input  logic            rst_n,
    tt_eval_seq_if.slave    bus
);
    localparam int TT_W = 1 << N_IN;
    localparam int SC_W = $clog2(SETTLE + 1);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t            state_q;
    logic [TT_W-1:0]   tt_active_q;
    logic [TT_W-1:0]   shadow_q;
    logic [N_IN-1:0]   bit_cnt_q;
    logic              ld_ready_q;
    logic              ld_done_q;

    logic [N_IN-1:0]   in_q;
    logic [SC_W-1:0]   stab_cnt_q;
    logic              out_q;
    logic              out_valid_q;
    logic              out_changed_q;

    logic              accept_d;
    logic              commit_d;
    logic              func_d;
    logic [TT_W-1:0]   tt_new_d;

    // A restart pulse takes priority over a bit offered in the same cycle.
    assign accept_d = (state_q == LOAD) && ld_ready_q && bus.ld_valid && !bus.ld_start;
    assign commit_d = accept_d && (bit_cnt_q == N_IN'(TT_W - 1));
    assign tt_new_d = {shadow_q[TT_W-2:0], bus.ld_bit};

    // Table MSB belongs to the all-zero input, so the bit index is the bitwise inverse of in_q.
    assign func_d = tt_active_q[~in_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shadow_q    <= '0;
            tt_active_q <= DEFAULT_TT;
            ld_ready_q  <= 1'b0;
            ld_done_q   <= 1'b0;
        end else begin
            ld_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.ld_start) begin
                        state_q    <= LOAD;
                        bit_cnt_q  <= '0;
                        ld_ready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.ld_start) begin
                        bit_cnt_q <= '0;
                    end else if (accept_d) begin
                        shadow_q  <= tt_new_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (commit_d) begin
                            tt_active_q <= tt_new_d;
                            state_q     <= IDLE;
                            ld_ready_q  <= 1'b0;
                            ld_done_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ld_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // A commit restarts the settle count so the new table is only seen on a settled output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q          <= '0;
            stab_cnt_q    <= '0;
            out_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_changed_q <= 1'b0;
        end else begin
            out_changed_q <= 1'b0;
            if (bus.in != in_q) begin
                in_q        <= bus.in;
                stab_cnt_q  <= '0;
                out_valid_q <= 1'b0;
            end else if (stab_cnt_q < SC_W'(SETTLE)) begin
                stab_cnt_q <= stab_cnt_q + 1'b1;
                if ((stab_cnt_q == SC_W'(SETTLE - 1)) && !commit_d) begin
                    out_q         <= func_d;
                    out_valid_q   <= 1'b1;
                    out_changed_q <= (func_d != out_q);
                end
            end
            if (commit_d) begin
                stab_cnt_q  <= '0;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ld_ready    = ld_ready_q;
    assign bus.ld_done     = ld_done_q;
    assign bus.out         = out_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_changed = out_changed_q;

endmodule

// File: tb/tb_tt_eval_seq.sv
// Self-checking bench for tt_eval_seq: directed scenarios plus random inputs and loads,
// compared every cycle against a queue-based behavioural model of the gate.
module tb_tt_eval_seq;
    localparam int         N_IN       = 3;
    localparam int         SETTLE     = 4;
    localparam int         TT_W       = 8;
    localparam logic [7:0] DEFAULT_TT = 8'h3B;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int testCount    = 0;
    int errCount     = 0;
    int changedCount = 0;
    int doneCount    = 0;
    bit checkEn      = 1'b0;

    logic [7:0] mTable;
    bit         mLoading;
    bit         mBits[$];
    logic       mReady;
    logic       mDone;
    logic       mOut;
    logic       mValid;
    logic       mChanged;
    logic [2:0] mIn;
    int         mStable;

    tt_eval_seq_if #(.N_IN(N_IN)) bus ();

    tt_eval_seq #(
        .N_IN       (N_IN),
        .SETTLE     (SETTLE),
        .DEFAULT_TT (DEFAULT_TT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic ttLookup(input logic [7:0] table_v, input int idx);
        return table_v[7 - idx];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mTable   = DEFAULT_TT;
        mLoading = 1'b0;
        mBits.delete();
        mReady   = 1'b0;
        mDone    = 1'b0;
        mOut     = 1'b0;
        mValid   = 1'b0;
        mChanged = 1'b0;
        mIn      = '0;
        mStable  = 0;
    endtask

    // Behavioural view: collect accepted bits in a queue, swap the table in when full.
    task automatic modelEdge();
        logic [7:0] newTable;
        bit         commit;
        logic       v;
        if (!rst_n) begin
            modelReset();
            return;
        end
        commit   = 1'b0;
        newTable = mTable;
        mDone    = 1'b0;
        mChanged = 1'b0;
        if (mLoading) begin
            if (bus.ld_start) begin
                mBits.delete();
            end else if (bus.ld_valid) begin
                mBits.push_back(bus.ld_bit);
                if (mBits.size() == TT_W) begin
                    newTable = '0;
                    foreach (mBits[j]) newTable = {newTable[6:0], mBits[j]};
                    commit   = 1'b1;
                    mLoading = 1'b0;
                    mBits.delete();
                end
            end
        end else if (bus.ld_start) begin
            mLoading = 1'b1;
            mBits.delete();
        end
        mReady = mLoading;
        if (bus.in !== mIn) begin
            mIn     = bus.in;
            mStable = 0;
            mValid  = 1'b0;
        end else if (mStable < SETTLE) begin
            mStable++;
            if (mStable == SETTLE && !commit) begin
                v        = ttLookup(mTable, int'(mIn));
                mChanged = (v != mOut);
                mOut     = v;
                mValid   = 1'b1;
            end
        end
        if (commit) begin
            mStable = 0;
            mValid  = 1'b0;
            mTable  = newTable;
            mDone   = 1'b1;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        if (bus.out_changed) changedCount++;
        if (bus.ld_done) doneCount++;
        if (checkEn) begin
            checkOutput("out", bus.out, mOut);
            checkOutput("out_valid", bus.out_valid, mValid);
            checkOutput("out_changed", bus.out_changed, mChanged);
            checkOutput("ld_ready", bus.ld_ready, mReady);
            checkOutput("ld_done", bus.ld_done, mDone);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] inVal, input int cycles);
        bus.in = inVal;
        repeat (cycles) stepCycle();
    endtask

    // Sends the top 'count' bits of value MSB first, optionally with valid gaps and input jitter.
    task automatic loadBits(input logic [7:0] value, input int count, input bit doStart,
                            input bit gaps, input bit jitter);
        if (doStart) begin
            bus.ld_start = 1'b1;
            stepCycle();
            bus.ld_start = 1'b0;
        end
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                bus.ld_valid = 1'b0;
                bus.ld_bit   = 1'($urandom_range(0, 1));
                repeat (g) stepCycle();
            end
            if (jitter && $urandom_range(0, 2) == 0) bus.in = 3'($urandom_range(0, 7));
            bus.ld_valid = 1'b1;
            bus.ld_bit   = value[7 - i];
            stepCycle();
        end
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        logic expSeq[8];
        int   c0;
        int   d0;
        expSeq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        modelReset();
        bus.in       = 3'b010;
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_bit   = 1'b0;
        checkEn      = 1'b1;

        // Scenario 1: reset values, then first settled output with the default table.
        repeat (2) stepCycle();
        checkOutput("rst_out", bus.out, 1'b0);
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_ld_ready", bus.ld_ready, 1'b0);
        rst_n = 1'b1;
        applyStimulus(3'b010, 6);
        checkOutput("s1_out", bus.out, 1'b1);
        checkOutput("s1_out_valid", bus.out_valid, 1'b1);
        checkOutput("s1_changed_cnt", 32'(changedCount), 32'd1);

        // Scenario 2: two-cycle glitch is rejected.
        c0 = changedCount;
        applyStimulus(3'b101, 2);
        checkOutput("s2_glitch_valid", bus.out_valid, 1'b0);
        checkOutput("s2_glitch_out", bus.out, 1'b1);
        applyStimulus(3'b010, 6);
        checkOutput("s2_out", bus.out, 1'b1);
        checkOutput("s2_out_valid", bus.out_valid, 1'b1);
        checkOutput("s2_no_change", 32'(changedCount - c0), 32'd0);

        // Scenario 3: sweep with the default table.
        c0 = changedCount;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 6);
            checkOutput($sformatf("s3_sweep%0d", i), bus.out, expSeq[i]);
        end
        checkOutput("s3_toggles", 32'(changedCount - c0), 32'd4);

        // Scenario 4: load 8'h96 with gaps while in=001 holds, then sweep the new table.
        applyStimulus(3'b001, 6);
        d0 = doneCount;
        loadBits(8'h96, 8, 1'b1, 1'b1, 1'b0);
        applyStimulus(3'b001, 6);
        checkOutput("s4_done_cnt", 32'(doneCount - d0), 32'd1);
        checkOutput("s4_out", bus.out, ttLookup(8'h96, 1));
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 6);
            checkOutput($sformatf("s4_sweep%0d", i), bus.out, ttLookup(8'h96, i));
        end

        // Scenario 5: aborted partial load, then full load of 8'h01.
        d0 = doneCount;
        loadBits(8'hA5, 5, 1'b1, 1'b0, 1'b0);
        loadBits(8'h01, 8, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b000, 6);
        checkOutput("s5_done_cnt", 32'(doneCount - d0), 32'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 6);
            checkOutput($sformatf("s5_sweep%0d", i), bus.out, (i == 7) ? 1'b1 : 1'b0);
        end

        // Scenario 6: reset in the middle of a load restores the default table.
        loadBits(8'hFF, 3, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        modelReset();
        repeat (2) stepCycle();
        checkOutput("s6_ld_ready", bus.ld_ready, 1'b0);
        checkOutput("s6_out", bus.out, 1'b0);
        bus.in = 3'b100;
        rst_n  = 1'b1;
        applyStimulus(3'b100, 6);
        checkOutput("s6_out_after", bus.out, 1'b1);
        checkOutput("s6_valid_after", bus.out_valid, 1'b1);

        // Random phase: input changes, loads with jitter, and restart overlapping a valid bit.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0, 1: applyStimulus(3'($urandom_range(0, 7)), $urandom_range(1, 7));
                2:    loadBits(8'($urandom), 8, 1'b1, 1'b1, 1'b1);
                default: begin
                    loadBits(8'($urandom), $urandom_range(1, 7), 1'b1, 1'b1, 1'b1);
                    bus.ld_start = 1'b1;
                    bus.ld_valid = 1'b1;
                    bus.ld_bit   = 1'($urandom_range(0, 1));
                    stepCycle();
                    bus.ld_start = 1'b0;
                    loadBits(8'($urandom), 8, 1'b0, 1'b1, 1'b1);
                end
            endcase
        end
        applyStimulus(bus.in, 8);
        checkOutput("final_valid", bus.out_valid, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testCount, errCount);
        $finish;
    end

endmodule
